soc_bus_fabric: RTL and testbench

//  Parametrised memory-mapped interconnect between the MIPS core data port and NSLV peripherals
//  (dmem, fact, gpio, ...). Decodes slave select from address, broadcasts addr/wdata, muxes read data.

---
 rtl/soc_bus_pkg.sv | 18 +
 rtl/soc_bus_fabric_if.sv | 31 +++
 rtl/soc_bus_fabric_addr_dec.sv | 39 +++
 rtl/soc_bus_fabric.sv | 134 +++++++++++++
 tb/tb_soc_bus_fabric.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the core-to-peripheral bus fabric.
package soc_bus_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Width of the slave-select field; a single slave still gets a 1-bit field tied to zero.
  function automatic int sel_width(input int nslv);
    return (nslv > 1) ? $clog2(nslv) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_fabric_if.sv
// Core data port plus peripheral-side bus, bundled for the fabric.
interface soc_bus_fabric_if #(
  parameter int NSLV = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic               m_req;
  logic               m_we;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic [DW-1:0]      m_rdata;
  logic               m_stall;
  logic               m_err;
  logic [NSLV-1:0]    s_req;
  logic [NSLV-1:0]    s_we;
  logic [AW-1:0]      s_addr;
  logic [DW-1:0]      s_wdata;
  logic [NSLV*DW-1:0] s_rdata;
  logic [NSLV-1:0]    s_ready;

  // master: the core and peripherals around the fabric; slave: the fabric itself.
  modport master (
    output m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    input  m_rdata, m_stall, m_err, s_req, s_we, s_addr, s_wdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ready,
    output m_rdata, m_stall, m_err, s_req, s_we, s_addr, s_wdata
  );
endinterface

// File: rtl/soc_bus_fabric_addr_dec.sv
// Slave-select decode: select field, mapped flag and one-hot slave vector.
module bus_addr_dec
  import soc_bus_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int AW      = 32,
  parameter int SEL_LSB = 8,
  parameter int SW      = sel_width(NSLV)
) (
  input  logic [AW-1:0]   addr,
  output logic [SW-1:0]   sel,
  output logic            mapped,
  output logic [NSLV-1:0] onehot
);

  localparam logic [SW:0] NSLV_V = (SW+1)'(NSLV);

  logic unused_addr;

  generate
    if (NSLV > 1) begin : g_sel
      assign sel = addr[SEL_LSB +: SW];
    end else begin : g_nosel
      assign sel = '0;
    end
  endgenerate

  assign unused_addr = ^addr;
  assign mapped      = ({1'b0, sel} < NSLV_V);

  // Unmapped selects match no index, so the vector is all-zero for them.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel == SW'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// Memory-mapped interconnect: decode, wait-state handshake, timeout abort and error log.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int            NSLV     = 4,
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            SEL_LSB  = 8,
  parameter int            TIMEOUT  = 16,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  soc_bus_fabric_if.slave      bus,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [AW-1:0]        err_addr
);

  localparam int SW = sel_width(NSLV);
  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  state_t          state;
  logic [7:0]      wait_cnt;
  logic [AW-1:0]   lat_addr;
  logic            lat_we;
  logic [DW-1:0]   lat_wdata;

  logic            in_wait;
  logic            active;
  logic [AW-1:0]   cur_addr;
  logic            cur_we;
  logic [DW-1:0]   cur_wdata;
  logic [SW-1:0]   sel;
  logic            mapped;
  logic [NSLV-1:0] onehot;
  logic            ready_sel;
  logic [DW-1:0]   rdata_sel;
  logic            timed_out;
  logic            err_now;

  // While waiting the core's m_* are ignored; everything follows the latched access.
  assign in_wait   = (state == S_WAIT);
  assign active    = in_wait || bus.m_req;
  assign cur_addr  = in_wait ? lat_addr  : bus.m_addr;
  assign cur_we    = in_wait ? lat_we    : bus.m_we;
  assign cur_wdata = in_wait ? lat_wdata : bus.m_wdata;

  bus_addr_dec #(
    .NSLV   (NSLV),
    .AW     (AW),
    .SEL_LSB(SEL_LSB),
    .SW     (SW)
  ) u_dec (
    .addr  (cur_addr),
    .sel   (sel),
    .mapped(mapped),
    .onehot(onehot)
  );

  always_comb begin
    rdata_sel = '0;
    ready_sel = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (onehot[i]) begin
        rdata_sel = bus.s_rdata[i*DW +: DW];
        ready_sel = bus.s_ready[i];
      end
    end
  end

  // A ready slave in the final wait cycle completes normally rather than erroring.
  assign timed_out = in_wait && (wait_cnt == TIMEOUT_V);
  assign err_now   = rst && active && (!mapped || (!ready_sel && timed_out));
  assign bus.m_err = err_now;

  always_comb begin
    bus.s_addr  = cur_addr;
    bus.s_wdata = cur_wdata;
    bus.s_req   = '0;
    bus.s_we    = '0;
    bus.m_rdata = '0;
    bus.m_stall = 1'b0;
    if (rst && active) begin
      if (err_now) begin
        bus.m_rdata = ERR_DATA;
      end else begin
        bus.s_req = onehot;
        bus.s_we  = cur_we ? onehot : '0;
        if (ready_sel) begin
          if (!cur_we) bus.m_rdata = rdata_sel;
        end else begin
          bus.m_stall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      err_cnt   <= '0;
      err_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.m_req && mapped && !ready_sel) begin
            lat_addr  <= bus.m_addr;
            lat_we    <= bus.m_we;
            lat_wdata <= bus.m_wdata;
            wait_cnt  <= 8'd1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ready_sel || timed_out) begin
            wait_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
      endcase
      if (err_now) begin
        if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
        err_addr <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: directed scenarios plus randomized latency traffic.
module tb_soc_bus_fabric;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0]    err_cnt4, err_cnt3;
  logic [AW-1:0] err_addr4, err_addr3;

  int n_checks = 0;
  int n_pass = 0;
  int exp_err4 = 0;
  logic [AW-1:0] exp_eaddr4 = '0;

  soc_bus_fabric_if #(.NSLV(4), .AW(AW), .DW(DW)) bus4 ();
  soc_bus_fabric_if #(.NSLV(3), .AW(AW), .DW(DW)) bus3 ();

  soc_bus_fabric #(.NSLV(4), .AW(AW), .DW(DW), .SEL_LSB(8), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .err_cnt(err_cnt4), .err_addr(err_addr4));

  soc_bus_fabric #(.NSLV(3), .AW(AW), .DW(DW), .SEL_LSB(8), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .err_cnt(err_cnt3), .err_addr(err_addr3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus4.m_req = 1'b0; bus4.m_we = 1'b0; bus4.m_addr = '0; bus4.m_wdata = '0;
    bus4.s_rdata = '0; bus4.s_ready = '0;
    bus3.m_req = 1'b0; bus3.m_we = 1'b0; bus3.m_addr = '0; bus3.m_wdata = '0;
    bus3.s_rdata = '0; bus3.s_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus4.m_req = 1'b1; bus4.m_addr = 32'h0000_0104; bus4.s_ready = 4'hF;
    bus4.s_rdata = {4{32'h5555_AAAA}};
    bus3.m_req = 1'b1; bus3.m_addr = 32'h0000_0300;
    tick(); tick(); #3;
    n_checks++;
    if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata} !== 42'b0)
      $display("[TB] FAIL reset_outputs4 got=%h exp=0", {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata});
    else n_pass++;
    n_checks++;
    if ({bus3.m_stall, bus3.m_err, bus3.s_req, bus3.s_we, bus3.m_rdata} !== 40'b0)
      $display("[TB] FAIL reset_outputs3 got=%h exp=0", {bus3.m_stall, bus3.m_err, bus3.s_req, bus3.s_we, bus3.m_rdata});
    else n_pass++;
    n_checks++;
    if ({err_cnt4, err_addr4, err_cnt3, err_addr3} !== 80'b0)
      $display("[TB] FAIL reset_errlog got=%h exp=0", {err_cnt4, err_addr4, err_cnt3, err_addr3});
    else n_pass++;
    idle_all();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    bus4.m_req = 1'b1; bus4.m_we = 1'b0; bus4.m_addr = 32'h0000_0104;
    bus4.s_rdata = {$urandom, $urandom, $urandom, $urandom};
    bus4.s_rdata[63:32] = 32'h0000_1234;
    bus4.s_ready = 4'b0010;
    #3;
    n_checks++;
    if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata} !== {2'b00, 4'b0010, 4'b0000, 32'h0000_1234})
      $display("[TB] FAIL zero_wait_read got=%h exp=%h", {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata},
               {2'b00, 4'b0010, 4'b0000, 32'h0000_1234});
    else n_pass++;
    tick();
    bus4.m_addr = 32'h0000_0010;
    bus4.s_rdata[31:0] = 32'hCAFE_0001;
    bus4.s_ready = 4'b0001;
    #3;
    n_checks++;
    if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata} !== {2'b00, 4'b0001, 4'b0000, 32'hCAFE_0001})
      $display("[TB] FAIL zero_wait_b2b got=%h exp=%h", {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata},
               {2'b00, 4'b0001, 4'b0000, 32'hCAFE_0001});
    else n_pass++;
    tick();
    idle_all();
  endtask

  task automatic test_wait_states();
    logic [73:0] exp_v;
    for (int k = 0; k <= 3; k++) begin
      bus4.m_req = 1'b1; bus4.m_we = 1'b1; bus4.m_addr = 32'h0000_0208; bus4.m_wdata = 32'h0000_00AA;
      bus4.s_ready = 4'($urandom) & 4'b1011;
      if (k == 3) bus4.s_ready[2] = 1'b1;
      #3;
      exp_v = {(k < 3), 1'b0, 4'b0100, 4'b0100, 32'h0000_0208, 32'h0000_00AA};
      n_checks++;
      if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.s_addr, bus4.s_wdata} !== exp_v)
        $display("[TB] FAIL wait_write_cycle%0d got=%h exp=%h", k,
                 {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.s_addr, bus4.s_wdata}, exp_v);
      else n_pass++;
      tick();
    end
    bus4.m_req = 1'b0;
    bus4.s_ready = 4'b0100;
    #3;
    n_checks++;
    if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we} !== 10'b0)
      $display("[TB] FAIL wait_single_completion got=%h exp=0", {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we});
    else n_pass++;
    tick();
    idle_all();
  endtask

  task automatic test_timeout();
    logic [41:0] exp_v;
    for (int pass = 0; pass < 2; pass++) begin
      bus4.s_rdata = {$urandom, $urandom, $urandom, $urandom};
      bus4.s_rdata[127:96] = 32'h7777_0003;
      for (int k = 0; k <= TIMEOUT; k++) begin
        bus4.m_req = 1'b1; bus4.m_we = 1'b0; bus4.m_addr = 32'h0000_030C;
        bus4.s_ready = 4'($urandom) & 4'b0111;
        if (pass == 1 && k == TIMEOUT) bus4.s_ready[3] = 1'b1;
        #3;
        if (k < TIMEOUT) exp_v = {2'b10, 4'b1000, 4'b0000, 32'h0};
        else if (pass == 0) exp_v = {2'b01, 4'b0000, 4'b0000, ERR_DATA};
        else exp_v = {2'b00, 4'b1000, 4'b0000, 32'h7777_0003};
        n_checks++;
        if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata} !== exp_v)
          $display("[TB] FAIL timeout_p%0d_cycle%0d got=%h exp=%h", pass, k,
                   {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata}, exp_v);
        else n_pass++;
        tick();
      end
      if (pass == 0) begin
        exp_err4++;
        exp_eaddr4 = 32'h0000_030C;
      end
      bus4.m_req = 1'b0;
      #3;
      n_checks++;
      if ({bus4.m_err, err_cnt4, err_addr4} !== {1'b0, 8'(exp_err4), exp_eaddr4})
        $display("[TB] FAIL timeout_p%0d_errlog got=%h exp=%h", pass, {bus4.m_err, err_cnt4, err_addr4},
                 {1'b0, 8'(exp_err4), exp_eaddr4});
      else n_pass++;
      tick();
    end
    idle_all();
  endtask

  task automatic test_unmapped();
    logic [31:0] addr;
    int exp_cnt;
    bus3.m_req = 1'b1; bus3.m_we = 1'b0; bus3.m_addr = 32'h0000_0300;
    bus3.s_ready = 3'b111; bus3.s_rdata = {$urandom, $urandom, $urandom};
    #3;
    n_checks++;
    if ({bus3.m_stall, bus3.m_err, bus3.s_req, bus3.s_we, bus3.m_rdata} !== {2'b01, 6'b0, ERR_DATA})
      $display("[TB] FAIL unmapped_read got=%h exp=%h", {bus3.m_stall, bus3.m_err, bus3.s_req, bus3.s_we, bus3.m_rdata},
               {2'b01, 6'b0, ERR_DATA});
    else n_pass++;
    tick();
    bus3.m_addr = 32'h0000_0204;
    bus3.s_rdata[95:64] = 32'h0BAD_F00D;
    bus3.s_ready = 3'b100;
    #3;
    n_checks++;
    if ({bus3.m_stall, bus3.m_err, bus3.s_req, bus3.s_we, bus3.m_rdata, err_cnt3, err_addr3} !==
        {2'b00, 3'b100, 3'b000, 32'h0BAD_F00D, 8'd1, 32'h0000_0300})
      $display("[TB] FAIL unmapped_then_mapped got=%h exp=%h",
               {bus3.m_stall, bus3.m_err, bus3.s_req, bus3.s_we, bus3.m_rdata, err_cnt3, err_addr3},
               {2'b00, 3'b100, 3'b000, 32'h0BAD_F00D, 8'd1, 32'h0000_0300});
    else n_pass++;
    tick();
    addr = '0;
    for (int i = 0; i < 260; i++) begin
      addr = $urandom;
      addr[9:8] = 2'b11;
      bus3.m_addr = addr; bus3.m_we = 1'($urandom_range(0, 1)); bus3.m_wdata = $urandom;
      bus3.s_ready = 3'($urandom);
      #3;
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      n_checks++;
      if ({bus3.m_err, bus3.m_stall, bus3.s_req, err_cnt3} !== {1'b1, 1'b0, 3'b000, 8'(exp_cnt)})
        $display("[TB] FAIL unmapped_burst%0d got=%h exp=%h", i, {bus3.m_err, bus3.m_stall, bus3.s_req, err_cnt3},
                 {1'b1, 1'b0, 3'b000, 8'(exp_cnt)});
      else n_pass++;
      tick();
    end
    bus3.m_req = 1'b0;
    #3;
    n_checks++;
    if ({err_cnt3, err_addr3} !== {8'hFF, addr})
      $display("[TB] FAIL unmapped_saturate got=%h exp=%h", {err_cnt3, err_addr3}, {8'hFF, addr});
    else n_pass++;
    tick();
    idle_all();
  endtask

  task automatic test_wait_ignore();
    logic [73:0] exp_v;
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) begin
        bus4.m_req = 1'b1; bus4.m_we = 1'b1; bus4.m_addr = 32'h0000_0208; bus4.m_wdata = 32'h0000_0055;
      end else begin
        bus4.m_req = 1'($urandom_range(0, 1)); bus4.m_we = 1'($urandom_range(0, 1));
        bus4.m_addr = $urandom; bus4.m_wdata = $urandom;
      end
      bus4.s_ready = (k == 4) ? 4'b0100 : (4'($urandom) & 4'b1011);
      #3;
      exp_v = {(k < 4), 1'b0, 4'b0100, 4'b0100, 32'h0000_0208, 32'h0000_0055};
      n_checks++;
      if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.s_addr, bus4.s_wdata} !== exp_v)
        $display("[TB] FAIL wait_ignore_cycle%0d got=%h exp=%h", k,
                 {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.s_addr, bus4.s_wdata}, exp_v);
      else n_pass++;
      tick();
    end
    idle_all();
  endtask

  task automatic test_reset_mid_wait();
    for (int k = 0; k < 3; k++) begin
      bus4.m_req = 1'b1; bus4.m_we = 1'b0; bus4.m_addr = 32'h0000_030C; bus4.s_ready = 4'b0000;
      #3;
      n_checks++;
      if (bus4.m_stall !== 1'b1) $display("[TB] FAIL midwait_stall%0d got=%b exp=1", k, bus4.m_stall);
      else n_pass++;
      tick();
    end
    rst = 1'b0;
    #3;
    n_checks++;
    if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata} !== 42'b0)
      $display("[TB] FAIL midwait_gated got=%h exp=0", {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata});
    else n_pass++;
    tick();
    rst = 1'b1;
    bus4.m_req = 1'b0; bus4.s_ready = 4'b1111;
    #3;
    n_checks++;
    if ({bus4.m_stall, bus4.m_err, bus4.s_req, err_cnt4, err_addr4} !== 46'b0)
      $display("[TB] FAIL midwait_after_reset got=%h exp=0", {bus4.m_stall, bus4.m_err, bus4.s_req, err_cnt4, err_addr4});
    else n_pass++;
    tick();
    bus4.m_req = 1'b1; bus4.m_addr = 32'h0000_0100; bus4.s_ready = 4'b0010;
    bus4.s_rdata[63:32] = 32'h0000_600D;
    #3;
    n_checks++;
    if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_addr, bus4.m_rdata} !== {2'b00, 4'b0010, 32'h0000_0100, 32'h0000_600D})
      $display("[TB] FAIL midwait_idle_again got=%h exp=%h", {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_addr, bus4.m_rdata},
               {2'b00, 4'b0010, 32'h0000_0100, 32'h0000_600D});
    else n_pass++;
    tick();
    idle_all();
    exp_err4 = 0;
    exp_eaddr4 = '0;
  endtask

  // Reference: an access to a slave first ready after L cycles completes at min(L, TIMEOUT),
  // erroring only when L exceeds TIMEOUT; errors counted with saturation at 255.
  task automatic test_random();
    logic [1:0]  sel;
    logic [31:0] addr, wdata, rd;
    logic        we, fail;
    logic [3:0]  oh, exp_we;
    logic [73:0] exp_s;
    logic [41:0] exp_c;
    int lat, done;
    for (int t = 0; t < 40; t++) begin
      sel = 2'($urandom_range(0, 3));
      addr = $urandom; addr[9:8] = sel;
      we = 1'($urandom_range(0, 1)); wdata = $urandom; rd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: lat = 0;
        8:          lat = TIMEOUT;
        9:          lat = TIMEOUT + 1 + int'($urandom_range(0, 5));
        default:    lat = int'($urandom_range(1, 5));
      endcase
      fail = (lat > TIMEOUT);
      done = fail ? TIMEOUT : lat;
      oh = 4'(1 << sel);
      exp_we = we ? oh : 4'b0;
      bus4.s_rdata = {$urandom, $urandom, $urandom, $urandom};
      bus4.s_rdata[sel*32 +: 32] = rd;
      for (int k = 0; k <= done; k++) begin
        bus4.m_req = 1'b1; bus4.m_we = we; bus4.m_addr = addr; bus4.m_wdata = wdata;
        bus4.s_ready = 4'($urandom);
        bus4.s_ready[sel] = (k >= lat);
        #3;
        if (k < done) begin
          exp_s = {2'b10, oh, exp_we, addr, wdata};
          n_checks++;
          if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.s_addr, bus4.s_wdata} !== exp_s)
            $display("[TB] FAIL rand%0d_stall%0d got=%h exp=%h", t, k,
                     {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.s_addr, bus4.s_wdata}, exp_s);
          else n_pass++;
        end else begin
          exp_c = fail ? {2'b01, 8'b0, ERR_DATA} : {2'b00, oh, exp_we, (we ? 32'h0 : rd)};
          n_checks++;
          if ({bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata} !== exp_c)
            $display("[TB] FAIL rand%0d_done got=%h exp=%h", t,
                     {bus4.m_stall, bus4.m_err, bus4.s_req, bus4.s_we, bus4.m_rdata}, exp_c);
          else n_pass++;
        end
        tick();
      end
      if (fail) begin
        exp_err4++;
        exp_eaddr4 = addr;
      end
      bus4.m_req = 1'b0;
      bus4.s_ready = 4'($urandom);
      #3;
      n_checks++;
      if ({bus4.m_stall, err_cnt4, err_addr4} !== {1'b0, 8'((exp_err4 > 255) ? 255 : exp_err4), exp_eaddr4})
        $display("[TB] FAIL rand%0d_errlog got=%h exp=%h", t, {bus4.m_stall, err_cnt4, err_addr4},
                 {1'b0, 8'((exp_err4 > 255) ? 255 : exp_err4), exp_eaddr4});
      else n_pass++;
      tick();
    end
    idle_all();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    idle_all();
    rst = 1'b0;
    tick();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_unmapped();
    test_wait_ignore();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
